// File: rtl/fir_mac_serial_if.sv
// Sample, result and coefficient-write signals of the serial FIR MAC.
// The slave modport is the filter; the master modport is the sample source/sink.
interface fir_mac_serial_if #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int OUT_WIDTH  = WIDTH + 3
) ();
    localparam int AW = $clog2(TAPS);

    logic signed [WIDTH-1:0]      in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         coef_we;
    logic [AW-1:0]                coef_addr;
    logic [COEF_WIDTH-1:0]        coef_data;
    logic                         coef_err;
    logic                         sat;

    modport slave (
        input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_data, out_valid, coef_err, sat
    );

    modport master (
        output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_data, out_valid, coef_err, sat
    );
endinterface

// File: rtl/fir_mac_serial.sv
// Direct-form FIR filter with runtime-loadable coefficients and a single
// time-multiplexed multiply-accumulate shared by all taps. Valid/ready on
// both sides; the result is rounded half toward +inf and saturated.
module fir_mac_serial #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int OUT_WIDTH  = WIDTH + 3,
    parameter int OUT_SHIFT  = COEF_WIDTH - 1
) (
    input  logic              CLK,
    input  logic              rst,
    fir_mac_serial_if.slave   bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + $clog2(TAPS);
    // Wide enough for the rounding add and for comparing against the output range.
    localparam int RW    = ((ACC_W + 1) > OUT_WIDTH) ? (ACC_W + 2) : (OUT_WIDTH + 1);

    localparam logic signed [RW-1:0] RND     = (RW'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                       state_q, state_d;
    logic                         live_q;
    logic signed [WIDTH-1:0]      d_q [TAPS];
    logic signed [WIDTH-1:0]      d_d [TAPS];
    logic signed [COEF_WIDTH-1:0] c_q [TAPS];
    logic signed [COEF_WIDTH-1:0] c_d [TAPS];
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [AW-1:0]                tap_q, tap_d;
    logic signed [OUT_WIDTH-1:0]  out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         sat_q, sat_d;
    logic                         err_q, err_d;

    logic                         addr_ok;
    logic                         accept;
    logic                         coef_wr;
    logic signed [PW-1:0]         prod;
    logic signed [RW-1:0]         rnd_sum;
    logic signed [RW-1:0]         r;

    if (TAPS == (1 << AW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = bus.coef_addr < AW'(TAPS);
    end

    assign bus.in_ready  = live_q && (state_q == IDLE);
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
    assign bus.coef_err  = err_q;

    assign accept  = bus.in_ready && bus.in_valid;
    assign coef_wr = bus.coef_we && (state_q == IDLE) && addr_ok;
    assign prod    = PW'(d_q[tap_q]) * PW'(c_q[tap_q]);
    assign rnd_sum = RW'(acc_q) + RND;
    assign r       = rnd_sum >>> OUT_SHIFT;

    // State register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers: delay line, coefficients, accumulator and result.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            live_q      <= 1'b0;
            d_q         <= '{default: '0};
            c_q         <= '{default: '0};
            acc_q       <= '0;
            tap_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            d_q         <= d_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    // Next state, sample shift, MAC step, coefficient write and result load.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        c_d         = c_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        err_d       = bus.coef_we && !coef_wr;

        if (coef_wr) c_d[bus.coef_addr] = bus.coef_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d[0] = bus.in_data;
                    for (int unsigned i = 1; i < TAPS; i++) d_d[AW'(i)] = d_q[AW'(i - 1)];
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + 1'b1;
                if (tap_q == AW'(TAPS - 1)) state_d = OUT;
            end
            OUT: begin
                // First OUT cycle registers the rounded/saturated result so that
                // rounding and clipping sit off the multiplier path.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    if (r > SAT_MAX) begin
                        out_d = OUT_MAX;
                        sat_d = 1'b1;
                    end else if (r < SAT_MIN) begin
                        out_d = OUT_MIN;
                        sat_d = 1'b1;
                    end else begin
                        out_d = OUT_WIDTH'(r);
                        sat_d = 1'b0;
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
